lz77_stream_decoder: RTL and testbench

Parametrised LZ77 token decoder, the inverse of the team's LZ77 encoder.
- Accepts (offset, length, literal, last) tokens and rebuilds the symbol stream from a ring-buffer history window.
- Emits at most one symbol per cycle with downstream backpressure, and pulses finish at end of stream.
- Serves as the loopback checker in encoder/decoder round-trip benches and as the standalone decompression path.

---
 rtl/lz77_pkg.sv | 27 ++
 rtl/lz77_window_ram.sv | 31 +++
 rtl/lz77_stream_decoder.sv | 190 +++++++++++++++++++
 tb/tb_lz77_stream_decoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lz77_pkg.sv
`default_nettype none
// ============================================================================
// lz77_pkg : defaults, FSM encoding and token type shared by LZ77 enc/dec
// Revision : 1.0
// ============================================================================
package lz77_pkg;

    localparam int LZ_DATA_W = 8;
    localparam int LZ_OFF_W  = 12;
    localparam int LZ_LEN_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_LIT  = 2'd2,
        S_DONE = 2'd3
    } lz77_state_e;

    typedef struct packed {
        logic [LZ_OFF_W-1:0]  off;
        logic [LZ_LEN_W-1:0]  len;
        logic [LZ_DATA_W-1:0] lit;
        logic                 last;
    } lz77_token_t;

endpackage : lz77_pkg
`default_nettype wire

// File: rtl/lz77_window_ram.sv
`default_nettype none
// ============================================================================
// lz77_window_ram : DEPTH x DATA_W history window, 1 write / 1 async read
// Revision : 1.0
// ============================================================================
module lz77_window_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read lets an overlapping copy see the symbol written last cycle
    assign o_rdata = mem[i_raddr];

endmodule : lz77_window_ram
`default_nettype wire

// File: rtl/lz77_stream_decoder.sv
`default_nettype none
// ============================================================================
// lz77_stream_decoder : rebuilds a symbol stream from LZ77 (off,len,lit) tokens
// Revision : 1.0
// ============================================================================
module lz77_stream_decoder
    import lz77_pkg::*;
#(
    parameter int DATA_W    = LZ_DATA_W,
    parameter int WIN_DEPTH = 4096,
    parameter int OFF_W     = LZ_OFF_W,
    parameter int LEN_W     = LZ_LEN_W,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              i_rdy,
    input  logic              i_en,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_lit,
    input  logic              i_last,
    output logic              o_en,
    input  logic              o_rdy,
    output logic [DATA_W-1:0] o_data,
    output logic              finish,
    output logic              err,
    output logic [CNT_W-1:0]  o_count
);

    localparam int AW = $clog2(WIN_DEPTH);
    localparam int CW = ((OFF_W > AW) ? OFF_W : AW) + 1;
    localparam logic [AW:0] FILL_MAX = (AW+1)'(WIN_DEPTH);

    lz77_state_e       state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d, rd_q, rd_d;
    logic [AW:0]       fill_q, fill_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] lit_q, lit_d;
    logic              last_q, last_d;
    logic              i_rdy_q, i_rdy_d;
    logic              o_en_q, o_en_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;
    logic              finish_q, finish_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              win_we;
    logic [DATA_W-1:0] win_wdata, win_rdata;
    logic              advance, unwritten, tok_bad;

    lz77_window_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (WIN_DEPTH),
        .AW     (AW)
    ) u_win (
        .clk     (clk),
        .i_we    (win_we),
        .i_waddr (wp_q),
        .i_wdata (win_wdata),
        .i_raddr (rd_q),
        .o_rdata (win_rdata)
    );

    assign advance   = !o_en_q || o_rdy;
    // Read and write pointers stay off_q apart, so a location is unwritten while off exceeds fill
    assign unwritten = CW'(off_q) > CW'(fill_q);
    assign tok_bad   = (i_len != '0) && ((i_off == '0) || (CW'(i_off) > CW'(fill_q)));

    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        rd_d      = rd_q;
        fill_d    = fill_q;
        off_d     = off_q;
        len_d     = len_q;
        lit_d     = lit_q;
        last_d    = last_q;
        o_en_d    = o_en_q;
        o_data_d  = o_data_q;
        finish_d  = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;
        win_we    = 1'b0;
        win_wdata = '0;

        if (o_en_q && o_rdy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (advance) begin
                    o_en_d = 1'b0;
                end
                if (i_en && i_rdy_q) begin
                    off_d  = i_off;
                    len_d  = i_len;
                    lit_d  = i_lit;
                    last_d = i_last;
                    rd_d   = wp_q - i_off[AW-1:0];
                    if (tok_bad) begin
                        err_d = 1'b1;
                    end
                    state_d = ((i_len != '0) && (i_off != '0)) ? S_COPY : S_LIT;
                end
            end
            S_COPY: begin
                if (advance) begin
                    win_wdata = unwritten ? '0 : win_rdata;
                    win_we    = 1'b1;
                    o_data_d  = win_wdata;
                    o_en_d    = 1'b1;
                    wp_d      = wp_q + AW'(1);
                    rd_d      = rd_q + AW'(1);
                    len_d     = len_q - LEN_W'(1);
                    fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + (AW+1)'(1);
                    if (len_q == LEN_W'(1)) begin
                        state_d = S_LIT;
                    end
                end
            end
            S_LIT: begin
                if (advance) begin
                    win_wdata = lit_q;
                    win_we    = 1'b1;
                    o_data_d  = lit_q;
                    o_en_d    = 1'b1;
                    wp_d      = wp_q + AW'(1);
                    fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + (AW+1)'(1);
                    state_d   = last_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (advance) begin
                    o_en_d   = 1'b0;
                    finish_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        i_rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wp_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
            off_q    <= '0;
            len_q    <= '0;
            lit_q    <= '0;
            last_q   <= 1'b0;
            i_rdy_q  <= 1'b0;
            o_en_q   <= 1'b0;
            o_data_q <= '0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            rd_q     <= rd_d;
            fill_q   <= fill_d;
            off_q    <= off_d;
            len_q    <= len_d;
            lit_q    <= lit_d;
            last_q   <= last_d;
            i_rdy_q  <= i_rdy_d;
            o_en_q   <= o_en_d;
            o_data_q <= o_data_d;
            finish_q <= finish_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign i_rdy   = i_rdy_q;
    assign o_en    = o_en_q;
    assign o_data  = o_data_q;
    assign finish  = finish_q;
    assign err     = err_q;
    assign o_count = cnt_q;

endmodule : lz77_stream_decoder
`default_nettype wire

// File: tb/tb_lz77_stream_decoder.sv
`default_nettype none
// ============================================================================
// tb_lz77_stream_decoder : directed + randomized bench with a history-queue model
// Revision : 1.0
// ============================================================================
module tb_lz77_stream_decoder;

    localparam int DATA_W    = 8;
    localparam int WIN_DEPTH = 16;
    localparam int OFF_W     = 5;
    localparam int LEN_W     = 4;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_rdy, i_en = 1'b0, i_last = 1'b0;
    logic [OFF_W-1:0]  i_off = '0;
    logic [LEN_W-1:0]  i_len = '0;
    logic [DATA_W-1:0] i_lit = '0;
    logic              o_en, o_rdy = 1'b1, finish, err;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_count;

    lz77_stream_decoder #(
        .DATA_W(DATA_W), .WIN_DEPTH(WIN_DEPTH), .OFF_W(OFF_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_rdy(i_rdy), .i_en(i_en), .i_off(i_off),
        .i_len(i_len), .i_lit(i_lit), .i_last(i_last), .o_en(o_en), .o_rdy(o_rdy),
        .o_data(o_data), .finish(finish), .err(err), .o_count(o_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0, fin_cnt = 0, fin_cyc = 0, stall_viol = 0, timeouts = 0;
    int rdy_mode = 0, pat_idx = 0;
    logic [DATA_W-1:0] outq[$];
    int                xcyc[$];
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    // reference model state: full emitted history since reset
    logic [DATA_W-1:0] hist[$];
    logic [DATA_W-1:0] expq[$];
    logic              exp_err = 1'b0;
    int                exp_fin = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (o_en && o_rdy) begin
                outq.push_back(o_data);
                xcyc.push_back(cyc);
            end
            if (finish) begin
                fin_cnt = fin_cnt + 1;
                fin_cyc = cyc;
            end
            if (prev_stall && (!o_en || o_data !== prev_data)) stall_viol = stall_viol + 1;
            prev_stall = o_en && !o_rdy;
            prev_data  = o_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       o_rdy = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            2:       o_rdy = 1'($urandom_range(0, 1));
            default: o_rdy = 1'b1;
        endcase
        pat_idx = pat_idx + 1;
    end

    task automatic model_reset();
        hist.delete();
        expq.delete();
        exp_err = 1'b0;
        exp_fin = 0;
    endtask

    task automatic model_token(input int off, input int len, input int lit, input bit last);
        int avail;
        if (len != 0 && (off == 0 || off > ((hist.size() < WIN_DEPTH) ? hist.size() : WIN_DEPTH)))
            exp_err = 1'b1;
        if (len != 0 && off != 0) begin
            for (int k = 0; k < len; k++) begin
                logic [DATA_W-1:0] s;
                avail = (hist.size() < WIN_DEPTH) ? hist.size() : WIN_DEPTH;
                s = (off > avail) ? '0 : hist[hist.size() - off];
                hist.push_back(s);
                expq.push_back(s);
            end
        end
        hist.push_back(DATA_W'(lit));
        expq.push_back(DATA_W'(lit));
        if (last) exp_fin = exp_fin + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_en  = 1'b0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        outq.delete();
        xcyc.delete();
        fin_cnt = 0;
        stall_viol = 0;
        timeouts = 0;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_tok(input int off, input int len, input int lit, input bit last);
        int k = 0;
        i_off = OFF_W'(off); i_len = LEN_W'(len); i_lit = DATA_W'(lit); i_last = last;
        i_en = 1'b1;
        while (!i_rdy && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (i_rdy) begin
            @(posedge clk); #1;
            model_token(off, len, lit, last);
        end else begin
            timeouts = timeouts + 1;
        end
        i_en = 1'b0;
    endtask

    task automatic wait_out(input int nsym, input int nfin, output bit to);
        int k = 0;
        while ((outq.size() < nsym || fin_cnt < nfin) && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        repeat (3) @(posedge clk);
        #1;
        to = (outq.size() < nsym || fin_cnt < nfin);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++; if ({i_rdy, o_en, finish, err} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {i_rdy, o_en, finish, err}); else n_pass++;
        n_checks++; if (o_data !== '0) $display("FAIL reset_data: got %0h expected 0", o_data); else n_pass++;
        n_checks++; if (o_count !== '0) $display("FAIL reset_count: got %0d expected 0", o_count); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++; if (i_rdy !== 1'b0) $display("FAIL reset_rdy_low: got %b expected 0", i_rdy); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (i_rdy !== 1'b1) $display("FAIL reset_rdy_rise: got %b expected 1", i_rdy); else n_pass++;
    endtask

    task automatic test_literal();
        bit to;
        do_reset();
        send_tok(0, 0, 8'h41, 1'b0);
        send_tok(0, 0, 8'h42, 1'b0);
        send_tok(0, 0, 8'h43, 1'b1);
        wait_out(3, 1, to);
        n_checks++; if (to || timeouts != 0) $display("FAIL lit_timeout: got %0d symbols expected 3", outq.size()); else n_pass++;
        n_checks++; if (outq.size() != 3 || outq[0] !== 8'h41 || outq[1] !== 8'h42 || outq[2] !== 8'h43)
            $display("FAIL lit_data: got %p expected 41 42 43", outq); else n_pass++;
        n_checks++; if (xcyc.size() != 3 || fin_cyc - xcyc[2] != 1 || fin_cnt != 1)
            $display("FAIL lit_finish: got fin_cnt %0d delay %0d expected 1 1", fin_cnt, fin_cyc - ((xcyc.size() == 3) ? xcyc[2] : 0)); else n_pass++;
        n_checks++; if (o_count !== 16'd3 || err !== 1'b0) $display("FAIL lit_count_err: got %0d/%b expected 3/0", o_count, err); else n_pass++;
    endtask

    task automatic test_overlap();
        bit to;
        do_reset();
        send_tok(0, 0, 8'h41, 1'b0);
        send_tok(1, 5, 8'h42, 1'b1);
        wait_out(7, 1, to);
        n_checks++; if (to || outq.size() != 7) $display("FAIL ovl_len: got %0d symbols expected 7", outq.size()); else n_pass++;
        if (outq.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (outq[i] !== ((i == 6) ? 8'h42 : 8'h41)) $display("FAIL ovl_sym%0d: got %0h expected %0h", i, outq[i], (i == 6) ? 8'h42 : 8'h41); else n_pass++;
            end
            n_checks++; if (xcyc[5] - xcyc[1] != 4) $display("FAIL ovl_burst: got span %0d expected 4", xcyc[5] - xcyc[1]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [DATA_W-1:0] ref_s[7];
        ref_s = '{8'h58, 8'h59, 8'h58, 8'h59, 8'h58, 8'h59, 8'h5A};
        do_reset();
        pat_idx = 0;
        rdy_mode = 1;
        send_tok(0, 0, 8'h58, 1'b0);
        send_tok(0, 0, 8'h59, 1'b0);
        send_tok(2, 4, 8'h5A, 1'b1);
        wait_out(7, 1, to);
        rdy_mode = 0;
        n_checks++; if (to || outq.size() != 7) $display("FAIL bp_len: got %0d symbols expected 7", outq.size()); else n_pass++;
        for (int i = 0; i < 7 && i < outq.size(); i++) begin
            n_checks++; if (outq[i] !== ref_s[i]) $display("FAIL bp_sym%0d: got %0h expected %0h", i, outq[i], ref_s[i]); else n_pass++;
        end
        n_checks++; if (stall_viol != 0) $display("FAIL bp_stall_hold: got %0d violations expected 0", stall_viol); else n_pass++;
        n_checks++; if (o_count !== 16'd7) $display("FAIL bp_count: got %0d expected 7", o_count); else n_pass++;
    endtask

    task automatic test_wrap();
        bit to;
        do_reset();
        for (int i = 0; i < 20; i++) send_tok(0, 0, i, 1'b0);
        send_tok(16, 3, 8'hFF, 1'b1);
        wait_out(24, 1, to);
        n_checks++; if (to || outq.size() != 24) $display("FAIL wrap_len: got %0d symbols expected 24", outq.size()); else n_pass++;
        if (outq.size() == 24) begin
            n_checks++; if (outq[20] !== 8'd4 || outq[21] !== 8'd5 || outq[22] !== 8'd6 || outq[23] !== 8'hFF)
                $display("FAIL wrap_copy: got %0h %0h %0h %0h expected 4 5 6 ff", outq[20], outq[21], outq[22], outq[23]); else n_pass++;
        end
        n_checks++; if (err !== 1'b0) $display("FAIL wrap_err: got %b expected 0", err); else n_pass++;
    endtask

    task automatic test_illegal();
        bit to;
        do_reset();
        send_tok(3, 2, 8'h51, 1'b0);
        wait_out(3, 0, to);
        n_checks++; if (err !== 1'b1) $display("FAIL ill_err_set: got %b expected 1", err); else n_pass++;
        n_checks++; if (to || outq.size() != 3 || outq[0] !== 8'h00 || outq[1] !== 8'h00 || outq[2] !== 8'h51)
            $display("FAIL ill_fill: got %p expected 0 0 51", outq); else n_pass++;
        send_tok(0, 2, 8'h52, 1'b1);
        wait_out(4, 1, to);
        n_checks++; if (to || outq.size() != 4 || outq[3] !== 8'h52) $display("FAIL ill_skip: got %p expected 0 0 51 52", outq); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL ill_err_sticky: got %b expected 1", err); else n_pass++;
    endtask

    task automatic test_reset_mid_copy();
        bit to;
        int k = 0;
        do_reset();
        send_tok(0, 0, 8'h50, 1'b0);
        send_tok(1, 15, 8'h53, 1'b0);
        while (outq.size() < 5 && k < 200) begin @(posedge clk); #1; k++; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_en !== 1'b0 || i_rdy !== 1'b0) $display("FAIL rst_mid_outs: got o_en %b i_rdy %b expected 0 0", o_en, i_rdy); else n_pass++;
        n_checks++; if (o_count !== '0) $display("FAIL rst_mid_count: got %0d expected 0", o_count); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        outq.delete(); xcyc.delete(); model_reset();
        fin_cnt = 0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (fin_cnt != 0) $display("FAIL rst_mid_nofinish: got %0d pulses expected 0", fin_cnt); else n_pass++;
        send_tok(0, 0, 8'h54, 1'b1);
        wait_out(1, 1, to);
        n_checks++; if (to || outq.size() != 1 || outq[0] !== 8'h54 || o_count !== 16'd1)
            $display("FAIL rst_mid_after: got %p count %0d expected 54 count 1", outq, o_count); else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        int off, len;
        bit last;
        do_reset();
        rdy_mode = 2;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0:       off = 0;
                1:       off = $urandom_range(17, 31);
                default: off = $urandom_range(1, 16);
            endcase
            len  = $urandom_range(0, 15);
            last = (t == 59) || ($urandom_range(0, 9) == 0);
            send_tok(off, len, $urandom_range(0, 255), last);
        end
        wait_out(expq.size(), exp_fin, to);
        rdy_mode = 0;
        n_checks++; if (to || timeouts != 0 || outq.size() != expq.size())
            $display("FAIL rand_len: got %0d symbols expected %0d", outq.size(), expq.size()); else n_pass++;
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            n_checks++; if (outq[i] !== expq[i]) $display("FAIL rand_sym%0d: got %0h expected %0h", i, outq[i], expq[i]); else n_pass++;
        end
        n_checks++; if (err !== exp_err) $display("FAIL rand_err: got %b expected %b", err, exp_err); else n_pass++;
        n_checks++; if (fin_cnt != exp_fin) $display("FAIL rand_finish: got %0d expected %0d", fin_cnt, exp_fin); else n_pass++;
        n_checks++; if (o_count !== CNT_W'(expq.size())) $display("FAIL rand_count: got %0d expected %0d", o_count, expq.size()); else n_pass++;
        n_checks++; if (stall_viol != 0) $display("FAIL rand_stall_hold: got %0d violations expected 0", stall_viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_literal();
        test_overlap();
        test_backpressure();
        test_wrap();
        test_illegal();
        test_reset_mid_copy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lz77_stream_decoder
`default_nettype wire
